// File: rtl/sodor_shim_pkg.sv
// Shared types and constants for the dmem latency shim.
// Imported by the shim top and its request FIFO.
package sodor_shim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DELAY = 3'd3,
    ST_RESP  = 3'd4
  } shim_state_e;

  localparam logic DMEM_FCN_RD = 1'b0;
  localparam logic DMEM_FCN_WR = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Request record layout: {addr, data, fcn}
  function automatic int req_width(input int bus_w);
    return 2 * bus_w + 1;
  endfunction

endpackage

// File: rtl/sodor_req_fifo.sv
// Synchronous request FIFO with show-ahead head and registered full flag.
// Push while full is only honoured together with a pop.
module sodor_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push)
             - CNT_W'(do_pop);
    full_d   = (cnt_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;

endmodule

// File: rtl/sodor_dmem_latency_shim.sv
// Dmem latency shim: queues core requests, issues one at a time,
// and delays each memory response; sticky watchdog on silent memory.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

module sodor_dmem_latency_shim
  import sodor_shim_pkg::*;
#(
  parameter int BUS_W      = `SIZE_OF_THE_BUS,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_req_valid,
  output logic             core_req_ready,
  input  logic [BUS_W-1:0] core_req_addr,
  input  logic [BUS_W-1:0] core_req_data,
  input  logic             core_req_fcn,
  output logic             core_resp_valid,
  output logic [BUS_W-1:0] core_resp_data,
  output logic             mem_req_valid,
  output logic [BUS_W-1:0] mem_req_addr,
  output logic [BUS_W-1:0] mem_req_data,
  output logic             mem_req_write_en,
  input  logic             mem_resp_valid,
  input  logic [BUS_W-1:0] mem_resp_data,
  output logic             err_timeout
);

  localparam int REQ_W = req_width(BUS_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int DLY_W = $clog2(LATENCY + 2);

  shim_state_e      state_q, state_d;
  logic [REQ_W-1:0] issue_q, issue_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [BUS_W-1:0] cap_q, cap_d;
  logic             err_q, err_d;

  logic             mreq_valid_q;
  logic [BUS_W-1:0] mreq_addr_q;
  logic [BUS_W-1:0] mreq_data_q;
  logic             mreq_we_q;
  logic             cresp_valid_q;
  logic [BUS_W-1:0] cresp_data_q;

  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [REQ_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo_count;
  logic             issuing;

  assign core_req_ready    = !fifo_full;
  assign fifo_push         = core_req_valid
                           && core_req_ready;
  assign unused_fifo_count = ^fifo_count;

  sodor_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({core_req_addr,
               core_req_data,
               core_req_fcn}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    wd_d     = wd_q;
    dly_d    = dly_q;
    cap_d    = cap_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          issue_d  = fifo_head;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + 1'b1;
        // A response landing on the last watchdog cycle still wins
        if (mem_resp_valid) begin
          cap_d = (issue_q[0] != DMEM_FCN_RD)
                ? '0 : mem_resp_data;
          dly_d   = DLY_W'(LATENCY);
          state_d = (LATENCY == 1)
                  ? ST_RESP : ST_DELAY;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cap_d   = BUS_W'(TIMEOUT_DATA);
          dly_d   = DLY_W'(LATENCY);
          state_d = (LATENCY == 1)
                  ? ST_RESP : ST_DELAY;
        end
      end
      ST_DELAY: begin
        dly_d = dly_q - 1'b1;
        if (dly_q <= DLY_W'(2)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign issuing = (state_d == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      issue_q       <= '0;
      wd_q          <= '0;
      dly_q         <= '0;
      cap_q         <= '0;
      err_q         <= 1'b0;
      mreq_valid_q  <= 1'b0;
      mreq_addr_q   <= '0;
      mreq_data_q   <= '0;
      mreq_we_q     <= 1'b0;
      cresp_valid_q <= 1'b0;
      cresp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      issue_q       <= issue_d;
      wd_q          <= wd_d;
      dly_q         <= dly_d;
      cap_q         <= cap_d;
      err_q         <= err_d;
      mreq_valid_q  <= issuing;
      mreq_addr_q   <= issuing
                     ? issue_d[REQ_W-1 -: BUS_W]
                     : '0;
      mreq_data_q   <= issuing
                     ? issue_d[BUS_W:1] : '0;
      mreq_we_q     <= issuing
                     && (issue_d[0] == DMEM_FCN_WR);
      cresp_valid_q <= (state_d == ST_RESP);
      cresp_data_q  <= (state_d == ST_RESP)
                     ? cap_d : '0;
    end
  end

  assign mem_req_valid    = mreq_valid_q;
  assign mem_req_addr     = mreq_addr_q;
  assign mem_req_data     = mreq_data_q;
  assign mem_req_write_en = mreq_we_q;
  assign core_resp_valid  = cresp_valid_q;
  assign core_resp_data   = cresp_data_q;
  assign err_timeout      = err_q;

endmodule
